// File: rtl/serial_pwd_lock_if.sv
// Keypad-side and actuator-side signals of the serial password lock.
// The lock itself connects through the slave modport.
interface serial_pwd_lock_if;
    logic       i_in;
    logic       i_in_valid;
    logic       i_clr;
    logic       i_prog_en;
    logic       o_unlock;
    logic       o_err;
    logic       o_locked_out;
    logic       o_prog_done;
    logic [3:0] o_fail_cnt;

    modport master (
        output i_in, i_in_valid, i_clr, i_prog_en,
        input  o_unlock, o_err, o_locked_out, o_prog_done, o_fail_cnt
    );

    modport slave (
        input  i_in, i_in_valid, i_clr, i_prog_en,
        output o_unlock, o_err, o_locked_out, o_prog_done, o_fail_cnt
    );
endinterface

// File: rtl/serial_pwd_lock.sv
// Bit-serial BCD password lock with retry limit, timed lockout, timed unlock
// window and in-field password reprogramming.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | waiting for the first bit of an entry
// S_INPUT   | shifting in a password attempt
// S_CHECK   | one-cycle compare of the attempt against the stored password
// S_OPEN    | unlock window, timer running
// S_PROG    | shifting in a replacement password
// S_LOCKOUT | too many failures, all inputs ignored until the timer expires
module serial_pwd_lock #(
    parameter int                  DIGITS         = 4,
    parameter logic [4*DIGITS-1:0] DEFAULT_PWD    = 16'h4475,
    parameter int                  MAX_TRIES      = 3,
    parameter int                  LOCKOUT_CYCLES = 1000,
    parameter int                  OPEN_CYCLES    = 50
) (
    input logic              clk,
    input logic              rst,
    serial_pwd_lock_if.slave bus
);
    localparam int PW      = 4 * DIGITS;
    localparam int CNT_W   = $clog2(PW + 1);
    localparam int TMR_MAX = (LOCKOUT_CYCLES > OPEN_CYCLES) ? LOCKOUT_CYCLES : OPEN_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PW);
    localparam logic [TMR_W-1:0] TMR_OPEN = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_LOCK = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [3:0]       TRIES    = 4'(MAX_TRIES);

    typedef enum logic [2:0] {
        S_IDLE, S_INPUT, S_CHECK, S_OPEN, S_PROG, S_LOCKOUT
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [PW-1:0]      r_shift, w_shift_nxt, w_shift_in;
    logic [PW-1:0]      r_pwd, w_pwd_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [TMR_W-1:0]   r_tmr, w_tmr_nxt;
    logic [3:0]         r_fail, w_fail_nxt, w_fail_inc;
    logic               r_bad, w_bad_nxt;
    logic               r_perr, w_perr_nxt;
    logic               r_pdone, w_pdone_nxt;
    logic               w_err;
    logic               w_digit_bad;
    logic               w_match;

    assign w_shift_in  = {r_shift[PW-2:0], bus.i_in};
    assign w_cnt_inc   = r_cnt + CNT_W'(1);
    // A digit is complete whenever the new bit count is a multiple of four.
    assign w_digit_bad = (w_cnt_inc[1:0] == 2'b00) && (w_shift_in[3:0] > 4'd9);
    assign w_match     = !r_bad && (r_shift == r_pwd);
    assign w_fail_inc  = (r_fail == TRIES) ? r_fail : r_fail + 4'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_pwd   <= DEFAULT_PWD;
            r_cnt   <= '0;
            r_tmr   <= '0;
            r_fail  <= '0;
            r_bad   <= 1'b0;
            r_perr  <= 1'b0;
            r_pdone <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_pwd   <= w_pwd_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tmr   <= w_tmr_nxt;
            r_fail  <= w_fail_nxt;
            r_bad   <= w_bad_nxt;
            r_perr  <= w_perr_nxt;
            r_pdone <= w_pdone_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_pwd_nxt   = r_pwd;
        w_cnt_nxt   = r_cnt;
        w_tmr_nxt   = (r_tmr != '0) ? r_tmr - TMR_W'(1) : r_tmr;
        w_fail_nxt  = r_fail;
        w_bad_nxt   = r_bad;
        w_perr_nxt  = 1'b0;
        w_pdone_nxt = 1'b0;
        w_err       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!bus.i_clr && bus.i_in_valid) begin
                    w_shift_nxt = PW'(bus.i_in);
                    w_cnt_nxt   = CNT_W'(1);
                    w_bad_nxt   = 1'b0;
                    w_state_nxt = S_INPUT;
                end
            end

            S_INPUT, S_PROG: begin
                if (bus.i_clr) begin
                    w_shift_nxt = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == CNT_FULL) begin
                    // Full entry sits here for one cycle before being acted on.
                    if (r_state == S_INPUT) begin
                        w_state_nxt = S_CHECK;
                    end else begin
                        w_pwd_nxt   = r_shift;
                        w_pdone_nxt = 1'b1;
                        w_shift_nxt = '0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end
                end else if (bus.i_in_valid) begin
                    w_shift_nxt = w_shift_in;
                    w_cnt_nxt   = w_cnt_inc;
                    if (w_digit_bad) begin
                        if (r_state == S_INPUT) begin
                            w_bad_nxt   = 1'b1;
                            w_state_nxt = S_CHECK;
                        end else begin
                            w_perr_nxt  = 1'b1;
                            w_shift_nxt = '0;
                            w_cnt_nxt   = '0;
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
            end

            S_CHECK: begin
                w_shift_nxt = '0;
                w_cnt_nxt   = '0;
                w_bad_nxt   = 1'b0;
                if (w_match) begin
                    w_fail_nxt  = '0;
                    w_tmr_nxt   = TMR_OPEN;
                    w_state_nxt = S_OPEN;
                end else begin
                    w_err      = 1'b1;
                    w_fail_nxt = w_fail_inc;
                    if (w_fail_inc == TRIES) begin
                        w_tmr_nxt   = TMR_LOCK;
                        w_state_nxt = S_LOCKOUT;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end

            S_OPEN: begin
                if (bus.i_clr) begin
                    w_state_nxt = S_IDLE;
                end else if (bus.i_prog_en) begin
                    w_shift_nxt = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_PROG;
                end else if (r_tmr == '0) begin
                    w_state_nxt = S_IDLE;
                end
            end

            S_LOCKOUT: begin
                if (r_tmr == '0) begin
                    w_fail_nxt  = '0;
                    w_state_nxt = S_IDLE;
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Programming results surface the cycle after the decision edge.
    assign bus.o_unlock     = (r_state == S_OPEN);
    assign bus.o_locked_out = (r_state == S_LOCKOUT);
    assign bus.o_err        = w_err | r_perr;
    assign bus.o_prog_done  = r_pdone;
    assign bus.o_fail_cnt   = r_fail;
endmodule

// File: tb/tb_serial_pwd_lock.sv
// Self-checking bench for serial_pwd_lock: table-driven attempts, hand-written
// corner sequences and randomized bursts against a bit-queue reference model.
module tb_serial_pwd_lock;
    localparam int D      = 4;
    localparam int OPEN_N = 50;
    localparam int LOCK_N = 1000;
    localparam int MAXT   = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    serial_pwd_lock_if bus();

    serial_pwd_lock #(
        .DIGITS(D), .DEFAULT_PWD(16'h4475), .MAX_TRIES(MAXT),
        .LOCKOUT_CYCLES(LOCK_N), .OPEN_CYCLES(OPEN_N)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    int checks    = 0;
    int failures  = 0;
    int open_seen = 0;
    int lock_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: entered bits kept in a queue, password kept as a decimal number.
    typedef enum {M_IDLE, M_ENTRY, M_CHECK, M_OPEN, M_PROG, M_LOCK} mmode_t;
    mmode_t m_mode;
    bit     m_q[$];
    int     m_pwd, m_fail, m_left;
    bit     m_forced, m_perr, m_pdone;

    function automatic int q_dec();
        int v = 0;
        for (int d = 0; d < D; d++) begin
            int nib = 0;
            for (int b = 0; b < 4; b++) nib = nib * 2 + int'(m_q[4*d+b]);
            v = v * 10 + nib;
        end
        return v;
    endfunction

    function automatic int last_nib();
        int n = 0;
        int s = m_q.size();
        for (int k = s - 4; k < s; k++) n = n * 2 + int'(m_q[k]);
        return n;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r = '0;
        int x = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic m_reset();
        m_mode = M_IDLE; m_q.delete(); m_pwd = 4475; m_fail = 0; m_left = 0;
        m_forced = 0; m_perr = 0; m_pdone = 0;
    endtask

    function automatic logic [7:0] m_exp();
        logic e;
        e = m_perr || (m_mode == M_CHECK && (m_forced || q_dec() != m_pwd));
        return {m_mode == M_OPEN, e, m_mode == M_LOCK, m_pdone, 4'(m_fail)};
    endfunction

    task automatic m_step(input logic b, input logic v, input logic c, input logic p);
        bit nperr = 0;
        bit npdone = 0;
        case (m_mode)
            M_IDLE: if (!c && v) begin m_q.delete(); m_q.push_back(b); m_mode = M_ENTRY; end
            M_ENTRY, M_PROG: begin
                if (c) begin
                    m_q.delete(); m_mode = M_IDLE;
                end else if (m_q.size() == 4 * D) begin
                    if (m_mode == M_ENTRY) m_mode = M_CHECK;
                    else begin m_pwd = q_dec(); npdone = 1; m_q.delete(); m_mode = M_IDLE; end
                end else if (v) begin
                    m_q.push_back(b);
                    if (m_q.size() % 4 == 0 && last_nib() > 9) begin
                        if (m_mode == M_ENTRY) begin m_forced = 1; m_mode = M_CHECK; end
                        else begin nperr = 1; m_q.delete(); m_mode = M_IDLE; end
                    end
                end
            end
            M_CHECK: begin
                if (!m_forced && q_dec() == m_pwd) begin
                    m_fail = 0; m_left = OPEN_N; m_mode = M_OPEN;
                end else begin
                    if (m_fail < MAXT) m_fail++;
                    if (m_fail == MAXT) begin m_left = LOCK_N; m_mode = M_LOCK; end
                    else m_mode = M_IDLE;
                end
                m_q.delete(); m_forced = 0;
            end
            M_OPEN: begin
                m_left--;
                if (c) m_mode = M_IDLE;
                else if (p) begin m_q.delete(); m_mode = M_PROG; end
                else if (m_left == 0) m_mode = M_IDLE;
            end
            M_LOCK: begin
                m_left--;
                if (m_left == 0) begin m_fail = 0; m_mode = M_IDLE; end
            end
            default: m_mode = M_IDLE;
        endcase
        m_perr = nperr; m_pdone = npdone;
    endtask

    // One clock cycle: drive on the falling edge, sample 1ns later, then advance the model.
    task automatic cyc(input logic b, input logic v, input logic c, input logic p);
        logic [7:0] act, exp;
        @(negedge clk);
        bus.i_in = b; bus.i_in_valid = v; bus.i_clr = c; bus.i_prog_en = p;
        #1;
        act = {bus.o_unlock, bus.o_err, bus.o_locked_out, bus.o_prog_done, bus.o_fail_cnt};
        exp = m_exp();
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures < 20)
                $display("FAIL cycle_model t=%0t got %b expected %b", $time, act, exp);
        end
        if (bus.o_unlock === 1'b1) open_seen++;
        if (bus.o_locked_out === 1'b1) lock_seen++;
        m_step(b, v, c, p);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_code(input logic [15:0] code, input int gap);
        for (int i = 15; i >= 0; i--) begin
            if (gap > 0) idle($urandom_range(0, gap));
            cyc(code[i], 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.i_in = 0; bus.i_in_valid = 0; bus.i_clr = 0; bus.i_prog_en = 0;
        #1;
        m_reset();
        chk("reset_outputs", {bus.o_unlock, bus.o_err, bus.o_locked_out, bus.o_prog_done, bus.o_fail_cnt}, 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        logic [15:0] code;
        logic        exp_open;
        int          exp_fail;
    } vec_t;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vecs[8];
        vecs[0] = '{16'h4476, 1'b0, 1};
        vecs[1] = '{16'h4475, 1'b1, 0};
        vecs[2] = '{16'h1234, 1'b0, 1};
        vecs[3] = '{16'h0000, 1'b0, 2};
        vecs[4] = '{16'h4475, 1'b1, 0};
        vecs[5] = '{16'h9999, 1'b0, 1};
        vecs[6] = '{16'h0975, 1'b0, 2};
        vecs[7] = '{16'h4475, 1'b1, 0};

        bus.i_in = 0; bus.i_in_valid = 0; bus.i_clr = 0; bus.i_prog_en = 0;
        m_reset();

        // Default unlock: latency and window length.
        do_reset();
        send_code(16'h4475, 0);
        idle(1); chk("unlock_after_1", bus.o_unlock, 0);
        idle(1); chk("unlock_in_check", bus.o_unlock, 0);
        chk("err_in_check", bus.o_err, 0);
        open_seen = 0;
        idle(1); chk("unlock_rise", bus.o_unlock, 1);
        chk("fail_after_open", bus.o_fail_cnt, 0);
        for (int k = 0; k < 200 && bus.o_unlock === 1'b1; k++) idle(1);
        chk("open_len", open_seen, OPEN_N);

        // Table of whole attempts.
        do_reset();
        foreach (vecs[i]) begin
            send_code(vecs[i].code, 1);
            idle(2);
            chk("vec_err", bus.o_err, !vecs[i].exp_open);
            idle(1);
            chk("vec_unlock", bus.o_unlock, vecs[i].exp_open);
            chk("vec_fail", bus.o_fail_cnt, vecs[i].exp_fail);
            if (vecs[i].exp_open) cyc(1'b0, 1'b0, 1'b1, 1'b0);
        end

        // Lockout.
        do_reset();
        repeat (2) begin send_code(16'h1234, 0); idle(3); end
        lock_seen = 0;
        send_code(16'h1234, 0);
        idle(2); chk("lock_err", bus.o_err, 1);
        idle(1); chk("locked_out", bus.o_locked_out, 1);
        chk("lock_fail", bus.o_fail_cnt, MAXT);
        send_code(16'h4475, 0);
        chk("no_unlock_in_lock", bus.o_unlock, 0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("clr_ignored_lock", bus.o_locked_out, 1);
        for (int k = 0; k < 2000 && bus.o_locked_out === 1'b1; k++) idle(1);
        chk("lock_len", lock_seen, LOCK_N);
        chk("fail_after_lock", bus.o_fail_cnt, 0);
        send_code(16'h4475, 0); idle(3);
        chk("unlock_after_lock", bus.o_unlock, 1);

        // Invalid BCD first digit aborts after four bits.
        do_reset();
        cyc(1, 1, 0, 0); cyc(0, 1, 0, 0); cyc(1, 1, 0, 0); cyc(0, 1, 0, 0);
        idle(1); chk("bcd_err", bus.o_err, 1);
        idle(1); chk("bcd_fail", bus.o_fail_cnt, 1);
        send_code(16'h4475, 0); idle(3);
        chk("bcd_then_unlock", bus.o_unlock, 1);

        // Reprogramming; same-cycle bit with prog_en is discarded.
        do_reset();
        send_code(16'h4475, 0); idle(3);
        chk("prog_unlock", bus.o_unlock, 1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        send_code(16'h9081, 0);
        idle(1); chk("prog_done_early", bus.o_prog_done, 0);
        idle(1); chk("prog_done", bus.o_prog_done, 1);
        send_code(16'h4475, 0); idle(2);
        chk("old_pwd_err", bus.o_err, 1);
        idle(1); chk("old_pwd_locked", bus.o_unlock, 0);
        send_code(16'h9081, 0); idle(3);
        chk("new_pwd_unlock", bus.o_unlock, 1);
        do_reset();
        send_code(16'h4475, 0); idle(3);
        chk("default_after_reset", bus.o_unlock, 1);

        // clr mid-entry, then asynchronous reset inside the open window.
        do_reset();
        send_code(16'h4476, 0); idle(3);
        for (int i = 15; i >= 9; i--) cyc(to_bcd(4475)[i], 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        idle(1); chk("clr_no_err", bus.o_err, 0);
        chk("clr_fail_kept", bus.o_fail_cnt, 1);
        send_code(16'h4475, 0); idle(3);
        chk("clr_then_unlock", bus.o_unlock, 1);
        idle(10);
        #2 rst = 1'b0;
        #1;
        chk("async_reset_outs", {bus.o_unlock, bus.o_err, bus.o_locked_out, bus.o_prog_done, bus.o_fail_cnt}, 0);
        m_reset();
        @(negedge clk);
        rst = 1'b1;

        // Randomized bursts against the model.
        for (int n = 0; n < 40; n++) begin
            case ($urandom % 4)
                0: begin
                    send_code(to_bcd(m_pwd), 1); idle(3);
                    if ($urandom % 2 == 0) begin
                        cyc(1'($urandom % 2), 1'($urandom % 2), 1'b0, 1'b1);
                        send_code(to_bcd($urandom_range(0, 9999)), 1); idle(2);
                    end
                end
                1: repeat (20) cyc(1'($urandom % 2), 1'($urandom % 2),
                                   ($urandom % 20) == 0, ($urandom % 10) == 0);
                2: repeat (60) cyc(1'b0, 1'b0, ($urandom % 30) == 0, ($urandom % 8) == 0);
                default: begin send_code(to_bcd($urandom_range(0, 9999)), 1); idle(3); end
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
